ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
//
// PURPOSE
//   Shares one single-port synchronous data RAM between two requesters:
//   port A (CPU data path, ram_addr/ram_dout/ram_we side) and port B
//   (debug/DMA loader). Grants at most one access per clock and returns read
//   data one cycle later, tagged to the port that issued the read.
//   Sits between the cpu data-RAM interface and the RAM macro.
//
// PARAMETERS
//   DATA_WIDTH  16  RAM word width
//   ADDR_WIDTH  12  RAM address width
//   LOCK_MAX    8   max consecutive locked grants to port B (>=1)
//
// PORTS
//   i_clk     in   1    clock; all state changes on rising edge
//   i_rst     in   1    reset, synchronous, active-low
//   a_req     in   1    port A access request
//   a_we      in   1    port A write (1) / read (0)
//   a_addr    in   AW   port A address
//   a_wdata   in   DW   port A write data
//   a_gnt     out  1    port A access accepted this cycle
//   a_rvalid  out  1    port A read data valid
//   a_rdata   out  DW   port A read data
//   b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata   as port A, for B
//   b_lock    in   1    port B requests back-to-back priority (burst)
//   ram_addr  out  AW   RAM address
//   ram_dout  out  DW   RAM write data
//   ram_we    out  1    RAM write enable
//   ram_din   in   DW   RAM read data (valid 1 cycle after read address)
//
// BEHAVIOUR
//   - Handshake: requester holds req/we/addr/wdata stable until gnt=1.
//     Transfer completes in the gnt cycle. gnt is combinational from req
//     and registered arbiter state, with no req->gnt combinational loop.
//   - RAM drive: ram_addr/ram_dout/ram_we come from the granted port.
//     With no grant: ram_we=0, ram_addr=0, ram_dout=0.
//   - Read: x_rvalid is a registered 1-cycle pulse in the cycle after a read
//     grant. x_rdata=ram_din while x_rvalid=1, else 0. A write never
//     produces rvalid.
//   - Arbitration:
//     - FAIR state: single requester wins. If both request, the winner is the
//       port not granted last (last_winner register).
//   - Lock:
//     - A B grant with b_lock=1 enters LOCKED and sets lock_cnt=1.
//     - In LOCKED, B wins whenever b_req=1 and b_lock=1. Each B grant
//       increments lock_cnt.
//     - When lock_cnt==LOCK_MAX, the next cycle is forced FAIR with A
//       priority if a_req=1.
//   - LOCKED exits to FAIR (lock_cnt=0) when any of these holds:
//     b_lock=0, b_req=0, an A grant occurs, or LOCK_MAX is reached.
//   - last_winner updates on every grant.
//   - Reset (i_rst=0 at edge):
//     - State: FAIR, lock_cnt=0, last_winner=B (so A wins the first tie).
//     - Outputs: rvalid=0. While i_rst=0: gnt=0 and ram_we=0.
//   - Reset mid-operation: a read granted in the cycle before reset produces
//     no rvalid. No partial burst state survives reset.
//   - Simultaneous: exactly one gnt per cycle. a_gnt and b_gnt are never both 1.
//   - An rvalid from the previous read may coincide with a new grant
//     (full throughput: 1 access/cycle).
//
// TESTING
//   1 reset: i_rst=0 for 2 clks with a_req=b_req=1 -> no gnt, ram_we=0;
//     release -> a_gnt first.
//   2 A read addr 0x010 (RAM[0x010]=0xBEEF) -> a_gnt same cycle,
//     a_rvalid=1 next cycle with a_rdata=0xBEEF, b_rvalid=0.
//   3 both req continuously, no lock -> grants alternate A,B,A,B;
//     no two consecutive grants to the same port.
//   4 b_lock=1, b_req=1, a_req=1, LOCK_MAX=8 -> 8 consecutive b_gnt,
//     then one a_gnt, then B may re-lock.
//   5 B write 0x1234 @0x020 then A read @0x020 next cycle -> a_rdata=0x1234;
//     no rvalid for the write.
//   6 assert i_rst=0 the cycle after an A read grant -> a_rvalid stays 0.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle between two RAM requesters, the arbiter and the RAM macro.
// Ports: a_*/b_* requester handshakes, b_lock burst hint, ram_* macro side.
interface ram_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  b_lock;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_din;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata, b_lock,
    output b_gnt, b_rvalid, b_rdata,
    output ram_addr, ram_dout, ram_we,
    input  ram_din
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata, b_lock,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_addr, ram_dout, ram_we,
    output ram_din
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter for one single-port sync RAM, with B burst locking.
// Ports: i_clk, i_rst (sync, active-low), bus (ram_arbiter_if.slave).
module ram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int LOCK_MAX   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  ram_arbiter_if.slave bus
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    FAIR,
    LOCKED
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   cnt_nx;
  logic            last_b_q;
  logic            a_rv_q;
  logic            b_rv_q;
  logic            lock_win;
  logic            pick_b;
  logic            a_gnt;
  logic            b_gnt;
  logic            a_rvalid;
  logic            b_rvalid;

  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;
  logic                  we_mux;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= FAIR;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      a_rv_q   <= 1'b0;
      b_rv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (a_gnt || b_gnt) begin
        last_b_q <= b_gnt;
      end
      a_rv_q <= a_gnt && !bus.a_we;
      b_rv_q <= b_gnt && !bus.b_we;
    end
  end

  // The burst ends on the grant that reaches LOCK_MAX, so the
  // following cycle is already FAIR with last winner B (A first).
  always_comb begin
    state_d = FAIR;
    cnt_d   = '0;
    cnt_nx  = '0;
    if (b_gnt && bus.b_lock) begin
      cnt_nx = (state_q == LOCKED) ? cnt_q + 1'b1 : CW'(1);
      if (cnt_nx < CW'(LOCK_MAX)) begin
        state_d = LOCKED;
        cnt_d   = cnt_nx;
      end
    end
  end

  always_comb begin
    lock_win = (state_q == LOCKED) && bus.b_req && bus.b_lock;
    pick_b   = 1'b0;
    unique case (1'b1)
      lock_win:                             pick_b = 1'b1;
      (!lock_win && bus.a_req && bus.b_req): pick_b = !last_b_q;
      (!lock_win && !bus.a_req && bus.b_req): pick_b = 1'b1;
      default:                              pick_b = 1'b0;
    endcase
    a_gnt = i_rst && bus.a_req && !pick_b;
    b_gnt = i_rst && bus.b_req && pick_b;

    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    unique case (1'b1)
      a_gnt: begin
        addr_mux  = bus.a_addr;
        wdata_mux = bus.a_wdata;
        we_mux    = bus.a_we;
      end
      b_gnt: begin
        addr_mux  = bus.b_addr;
        wdata_mux = bus.b_wdata;
        we_mux    = bus.b_we;
      end
      default: begin
        addr_mux  = '0;
        wdata_mux = '0;
        we_mux    = 1'b0;
      end
    endcase
  end

  // A read granted just before reset must not surface during reset.
  assign a_rvalid = a_rv_q && i_rst;
  assign b_rvalid = b_rv_q && i_rst;

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_rvalid = a_rvalid;
  assign bus.b_rvalid = b_rvalid;
  assign bus.a_rdata  = a_rvalid ? bus.ram_din : '0;
  assign bus.b_rdata  = b_rvalid ? bus.ram_din : '0;
  assign bus.ram_addr = addr_mux;
  assign bus.ram_dout = wdata_mux;
  assign bus.ram_we   = we_mux;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural sync RAM.
// Directed grant sequences; read data checked by a separate monitor.
module tb_ram_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [15:0] mem [0:4095];
  logic [15:0] qa [$];
  logic [15:0] qb [$];

  ram_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) bus ();

  ram_arbiter #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(12),
    .LOCK_MAX  (8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_dout;
    bus.ram_din <= mem[bus.ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected word whenever a port presents rvalid.
  always @(negedge clk) begin
    if (bus.a_rvalid) begin
      if (qa.size() == 0) chk("a_rvalid_unexpected", 1, 0);
      else chk("a_rdata", bus.a_rdata, qa.pop_front());
    end else begin
      chk("a_rdata_idle", bus.a_rdata, 0);
    end
    if (bus.b_rvalid) begin
      if (qb.size() == 0) chk("b_rvalid_unexpected", 1, 0);
      else chk("b_rdata", bus.b_rdata, qb.pop_front());
    end else begin
      chk("b_rdata_idle", bus.b_rdata, 0);
    end
  end

  // One clock of stimulus: check grants and RAM drive, queue reads.
  task automatic step(input bit ea, input bit eb,
                      input logic [15:0] ed, input bit push);
    logic        ewe;
    logic [11:0] eaddr;
    logic [15:0] edat;
    @(negedge clk);
    ewe   = ea ? bus.a_we : (eb ? bus.b_we : 1'b0);
    eaddr = ea ? bus.a_addr : (eb ? bus.b_addr : 12'h0);
    edat  = ea ? bus.a_wdata : (eb ? bus.b_wdata : 16'h0);
    chk("a_gnt", bus.a_gnt, ea);
    chk("b_gnt", bus.b_gnt, eb);
    chk("ram_we", bus.ram_we, ewe);
    chk("ram_addr", bus.ram_addr, eaddr);
    if (ewe || !(ea || eb)) chk("ram_dout", bus.ram_dout, edat);
    if (push && ea && !bus.a_we) qa.push_back(ed);
    if (push && eb && !bus.b_we) qb.push_back(ed);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
    mem[12'h010] = 16'hBEEF;
    bus.ram_din  = 16'h0;
    rst          = 1'b0;
    bus.a_req    = 1'b1;
    bus.a_we     = 1'b1;
    bus.a_addr   = 12'h100;
    bus.a_wdata  = 16'h5555;
    bus.b_req    = 1'b1;
    bus.b_we     = 1'b1;
    bus.b_addr   = 12'h101;
    bus.b_wdata  = 16'h6666;
    bus.b_lock   = 1'b0;
    @(posedge clk);
    #1;

    // reset holds grants and write enable low
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b1;
    step(1, 0, 0, 1);
    bus.a_req = 1'b0;
    step(0, 1, 0, 1);

    // single A read
    bus.b_req  = 1'b0;
    bus.b_we   = 1'b0;
    bus.a_req  = 1'b1;
    bus.a_we   = 1'b0;
    bus.a_addr = 12'h010;
    step(1, 0, 16'hBEEF, 1);
    bus.a_req = 1'b0;
    step(0, 0, 0, 0);

    // both request, no lock: alternate, B first (A won last)
    bus.a_req  = 1'b1;
    bus.a_addr = 12'h100;
    bus.b_req  = 1'b1;
    bus.b_addr = 12'h101;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 16'h6666, 1);
      step(1, 0, 16'h5555, 1);
    end

    // lock burst: 8 B, forced A, B re-locks
    bus.a_addr = 12'h010;
    bus.b_lock = 1'b1;
    for (int i = 0; i < 8; i++) step(0, 1, 16'h6666, 1);
    step(1, 0, 16'hBEEF, 1);
    step(0, 1, 16'h6666, 1);
    step(0, 1, 16'h6666, 1);
    bus.b_lock = 1'b0;
    step(1, 0, 16'hBEEF, 1);
    step(0, 1, 16'h6666, 1);

    // B write then A read of the same word
    bus.a_req   = 1'b0;
    bus.b_we    = 1'b1;
    bus.b_addr  = 12'h020;
    bus.b_wdata = 16'h1234;
    step(0, 1, 0, 1);
    bus.b_req  = 1'b0;
    bus.b_we   = 1'b0;
    bus.a_req  = 1'b1;
    bus.a_addr = 12'h020;
    step(1, 0, 16'h1234, 1);

    // reset right after an A read grant kills its rvalid
    bus.a_addr = 12'h010;
    step(1, 0, 0, 0);
    rst       = 1'b0;
    bus.a_req = 1'b0;
    @(negedge clk);
    chk("rst_a_rvalid", bus.a_rvalid, 0);
    @(posedge clk);
    #1;
    bus.a_req  = 1'b1;
    bus.b_req  = 1'b1;
    bus.b_addr = 12'h101;
    bus.b_lock = 1'b1;
    step(0, 0, 0, 0);

    // after reset: A wins tie, then a fresh 8-grant burst
    rst = 1'b1;
    step(1, 0, 16'hBEEF, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 16'h6666, 1);
    step(1, 0, 16'hBEEF, 1);

    bus.a_req  = 1'b0;
    bus.b_req  = 1'b0;
    bus.b_lock = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
